// File: rtl/snic_imem_loader.sv
// snic_imem_loader: AXI-Lite write initiator that loads program words
// into SNIC IMEM, holding the core via the boot word until load completes.
module snic_imem_loader #(
    parameter logic [31:0] IMEM_BASE       = 32'h0000_0000,
    parameter logic [31:0] IMEM_SIZE_BYTES = 32'h0001_0000,
    parameter int unsigned B_TIMEOUT       = 1024
) (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic        start,
    input  logic [31:0] s_word_tdata,
    input  logic        s_word_tvalid,
    output logic        s_word_tready,
    input  logic        s_word_tlast,
    output logic [31:0] m_axil_awaddr,
    output logic        m_axil_awvalid,
    input  logic        m_axil_awready,
    output logic [31:0] m_axil_wdata,
    output logic [3:0]  m_axil_wstrb,
    output logic        m_axil_wvalid,
    input  logic        m_axil_wready,
    input  logic [1:0]  m_axil_bresp,
    input  logic        m_axil_bvalid,
    output logic        m_axil_bready,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [3:0] {
        IDLE, HALT_REQ, HALT_RSP, FETCH, WR_REQ,
        WR_RSP, BOOT_REQ, BOOT_RSP, DONE, ERR
    } state_t;

    localparam logic [31:0] BOOT_ADDR = IMEM_BASE + IMEM_SIZE_BYTES - 32'd4;
    localparam logic [31:0] TO_LAST   = 32'(B_TIMEOUT) - 32'd1;

    state_t      state;
    state_t      state_n;
    logic [31:0] addr;
    logic [31:0] tcnt;
    logic        aw_pend;
    logic        w_pend;
    logic        last_q;

    logic idle_like;
    logic req_done;
    logic b_ok;
    logic b_bad;
    logic b_to;
    logic enter_req;

    assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
    assign req_done  = (!aw_pend || m_axil_awready) && (!w_pend || m_axil_wready);
    assign b_ok      = m_axil_bvalid && (m_axil_bresp == 2'b00);
    assign b_bad     = m_axil_bvalid && (m_axil_bresp != 2'b00);
    assign b_to      = !m_axil_bvalid && (tcnt == TO_LAST);
    assign enter_req = (state_n != state) &&
                       ((state_n == HALT_REQ) || (state_n == WR_REQ) ||
                        (state_n == BOOT_REQ));

    assign m_axil_awvalid = aw_pend;
    assign m_axil_wvalid  = w_pend;
    assign m_axil_wstrb   = 4'hF;

    // state register
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) state <= IDLE;
        else             state <= state_n;
    end

    // next-state: one write in flight, response gates the next step
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE, ERR: if (start) state_n = HALT_REQ;
            HALT_REQ: if (req_done) state_n = HALT_RSP;
            HALT_RSP: begin
                if (b_ok)              state_n = FETCH;
                else if (b_bad || b_to) state_n = ERR;
            end
            FETCH: begin
                if (s_word_tvalid) begin
                    if (addr == BOOT_ADDR) state_n = ERR;
                    else                   state_n = WR_REQ;
                end
            end
            WR_REQ: if (req_done) state_n = WR_RSP;
            WR_RSP: begin
                if (b_ok)              state_n = last_q ? BOOT_REQ : FETCH;
                else if (b_bad || b_to) state_n = ERR;
            end
            BOOT_REQ: if (req_done) state_n = BOOT_RSP;
            BOOT_RSP: begin
                if (b_ok)              state_n = DONE;
                else if (b_bad || b_to) state_n = ERR;
            end
            default: state_n = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        s_word_tready = (state == FETCH);
        m_axil_bready = (state == HALT_RSP) || (state == WR_RSP) ||
                        (state == BOOT_RSP);
        busy          = !idle_like;
        done          = (state == DONE);
        error         = (state == ERR);
    end

    // datapath: address/data capture, handshake flags, counters
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            addr          <= 32'd0;
            tcnt          <= 32'd0;
            aw_pend       <= 1'b0;
            w_pend        <= 1'b0;
            last_q        <= 1'b0;
            word_count    <= 16'd0;
            m_axil_awaddr <= 32'd0;
            m_axil_wdata  <= 32'd0;
        end else begin
            if (idle_like && start) begin
                addr       <= IMEM_BASE;
                word_count <= 16'd0;
            end
            if (enter_req) begin
                aw_pend <= 1'b1;
                w_pend  <= 1'b1;
            end else begin
                if (aw_pend && m_axil_awready) aw_pend <= 1'b0;
                if (w_pend && m_axil_wready)   w_pend  <= 1'b0;
            end
            if (enter_req) begin
                case (state_n)
                    HALT_REQ: begin
                        m_axil_awaddr <= BOOT_ADDR;
                        m_axil_wdata  <= 32'd0;
                    end
                    WR_REQ: begin
                        m_axil_awaddr <= addr;
                        m_axil_wdata  <= s_word_tdata;
                    end
                    default: begin
                        m_axil_awaddr <= BOOT_ADDR;
                        m_axil_wdata  <= 32'd1;
                    end
                endcase
            end
            if (state == FETCH && s_word_tvalid) last_q <= s_word_tlast;
            if (state == WR_RSP && b_ok) begin
                addr <= addr + 32'd4;
                if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
            end
            if (m_axil_bready && state_n == state) tcnt <= tcnt + 32'd1;
            else                                   tcnt <= 32'd0;
        end
    end

endmodule

// File: tb/tb_snic_imem_loader.sv
// tb_snic_imem_loader: scoreboard bench with an AXI-Lite slave model
// and a word source; small IMEM (boot word at 0xC) and short B timeout.
module tb_snic_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    snic_imem_loader #(
        .IMEM_BASE       (32'h0000_0000),
        .IMEM_SIZE_BYTES (32'h0000_0010),
        .B_TIMEOUT       (16)
    ) dut (
        .core_clk       (clk),
        .core_rst_n     (rst_n),
        .start          (start),
        .s_word_tdata   (tdata),
        .s_word_tvalid  (tvalid),
        .s_word_tready  (tready),
        .s_word_tlast   (tlast),
        .m_axil_awaddr  (awaddr),
        .m_axil_awvalid (awvalid),
        .m_axil_awready (awready),
        .m_axil_wdata   (wdata),
        .m_axil_wstrb   (wstrb),
        .m_axil_wvalid  (wvalid),
        .m_axil_wready  (wready),
        .m_axil_bresp   (bresp),
        .m_axil_bvalid  (bvalid),
        .m_axil_bready  (bready),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .word_count     (word_count)
    );

    localparam logic [31:0] BOOT = 32'h0000_000C;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] sb[$];
    logic [32:0] src[$];

    int aw_delay = 0;
    int w_delay  = 0;
    int b_delay  = 0;
    int err_idx  = -1;
    int wr_idx   = 0;
    int n_b      = 0;
    bit no_b     = 0;
    bit lat_en   = 0;
    bit drop_chk = 0;

    bit          have_aw;
    bit          have_w;
    bit          aw_seen;
    bit          w_seen;
    bit          b_fire;
    bit          s_fire;
    int          aw_cnt;
    int          w_cnt;
    int          b_cnt;
    logic [31:0] aw_first;
    logic [31:0] w_first;
    logic [31:0] cap_addr;
    logic [31:0] cap_data;
    logic [63:0] exp_wr;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // AXI-Lite slave: decides ready/valid at negedge, handshake at posedge
    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                have_aw = 0; have_w = 0; aw_seen = 0; w_seen = 0;
                b_fire = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else begin
                if (b_fire) begin
                    bvalid = 0; have_aw = 0; have_w = 0;
                    aw_seen = 0; w_seen = 0; b_fire = 0; b_cnt = 0;
                end else if (have_aw && have_w && !bvalid && !no_b) begin
                    if (b_cnt >= b_delay) begin
                        bvalid = 1;
                        bresp = (wr_idx == err_idx) ? 2'b10 : 2'b00;
                        wr_idx++;
                        n_b++;
                        if (sb.size() == 0) begin
                            check("sb_underflow", 32'(sb.size()), 32'd1);
                        end else begin
                            exp_wr = sb.pop_front();
                            check("wr_addr", cap_addr, exp_wr[63:32]);
                            check("wr_data", cap_data, exp_wr[31:0]);
                        end
                    end else begin
                        b_cnt++;
                    end
                end
                if (have_aw) check("aw_one_out", 32'(awvalid), 32'd0);
                if (drop_chk && have_w && !have_aw)
                    check("w_drop", 32'(wvalid), 32'd0);
                if (awvalid && aw_seen && !have_aw)
                    check("aw_stable", awaddr, aw_first);
                if (wvalid && w_seen && !have_w)
                    check("w_stable", wdata, w_first);
                awready = 0;
                if (awvalid && !have_aw) begin
                    if (!aw_seen) begin aw_seen = 1; aw_first = awaddr; end
                    if (aw_cnt >= aw_delay) begin
                        awready = 1; have_aw = 1; cap_addr = awaddr; aw_cnt = 0;
                    end else aw_cnt++;
                end
                wready = 0;
                if (wvalid && !have_w) begin
                    if (!w_seen) begin w_seen = 1; w_first = wdata; end
                    if (w_cnt >= w_delay) begin
                        wready = 1; have_w = 1; cap_data = wdata; w_cnt = 0;
                        check("wstrb", 32'(wstrb), 32'hF);
                    end else w_cnt++;
                end
                b_fire = bvalid && bready;
            end
        end
    end

    // word source: presents head of src queue
    initial begin
        tvalid = 0; tdata = 0; tlast = 0; s_fire = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                tvalid = 0; s_fire = 0;
            end else begin
                if (lat_en && s_fire) check("aw_lat", 32'(awvalid), 32'd1);
                if (s_fire) void'(src.pop_front());
                if (src.size() > 0) begin
                    tvalid = 1;
                    {tlast, tdata} = src[0];
                end else begin
                    tvalid = 0;
                end
                s_fire = tvalid && tready;
            end
        end
    end

    task automatic do_reset();
        rst_n = 0;
        start = 0;
        repeat (3) @(negedge clk);
        sb.delete();
        src.delete();
        wr_idx = 0;
        n_b = 0;
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        int n;
        bit bad;
        rst_n = 0;
        start = 0;
        do_reset();

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(error), 32'd0);
        check("rst_awv", 32'(awvalid), 32'd0);
        check("rst_wv", 32'(wvalid), 32'd0);
        check("rst_trdy", 32'(tready), 32'd0);
        check("rst_brdy", 32'(bready), 32'd0);
        check("rst_wc", 32'(word_count), 32'd0);
        check("rst_awaddr", awaddr, 32'd0);
        check("rst_wdata", wdata, 32'd0);

        // three words, zero-wait slave
        sb.push_back({BOOT, 32'h0});
        sb.push_back({32'h0, 32'h11});
        sb.push_back({32'h4, 32'h22});
        sb.push_back({32'h8, 32'h33});
        sb.push_back({BOOT, 32'h1});
        src.push_back({1'b0, 32'h11});
        src.push_back({1'b0, 32'h22});
        src.push_back({1'b1, 32'h33});
        lat_en = 1;
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        lat_en = 0;
        check("t1_done", 32'(done), 32'd1);
        check("t1_err", 32'(error), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_wc", 32'(word_count), 32'd3);
        check("t1_sb_left", 32'(sb.size()), 32'd0);

        // restart from DONE, AW delayed 3 cycles, W immediate
        aw_delay = 3;
        drop_chk = 1;
        n_b = 0;
        sb.push_back({BOOT, 32'h0});
        sb.push_back({32'h0, 32'hCAFE_0001});
        sb.push_back({BOOT, 32'h1});
        src.push_back({1'b1, 32'hCAFE_0001});
        pulse_start();
        check("t2_done_clr", 32'(done), 32'd0);
        check("t2_wc_clr", 32'(word_count), 32'd0);
        n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        drop_chk = 0;
        aw_delay = 0;
        check("t2_done", 32'(done), 32'd1);
        check("t2_wc", 32'(word_count), 32'd1);
        check("t2_nb", 32'(n_b), 32'd3);
        check("t2_sb_left", 32'(sb.size()), 32'd0);

        // SLVERR on second program word
        do_reset();
        err_idx = 2;
        sb.push_back({BOOT, 32'h0});
        sb.push_back({32'h0, 32'hA1});
        sb.push_back({32'h4, 32'hA2});
        src.push_back({1'b0, 32'hA1});
        src.push_back({1'b0, 32'hA2});
        src.push_back({1'b1, 32'hA3});
        pulse_start();
        n = 0;
        while (!error && n < 300) begin @(negedge clk); n++; end
        check("t3_err", 32'(error), 32'd1);
        check("t3_wc", 32'(word_count), 32'd1);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (tready || awvalid || wvalid) bad = 1;
        end
        check("t3_quiet", 32'(bad), 32'd0);
        check("t3_done", 32'(done), 32'd0);
        check("t3_sb_left", 32'(sb.size()), 32'd0);
        err_idx = -1;

        // B never arrives: timeout in HALT_RSP
        do_reset();
        no_b = 1;
        sb.push_back({BOOT, 32'h0});
        pulse_start();
        n = 0;
        while (!bready && n < 50) begin @(negedge clk); n++; end
        check("t4_bready", 32'(bready), 32'd1);
        n = 0;
        while (!error && n < 40) begin @(negedge clk); n++; end
        check("t4_to_cycles", 32'(n), 32'd16);
        check("t4_err", 32'(error), 32'd1);
        no_b = 0;

        // program reaches the boot word
        do_reset();
        sb.push_back({BOOT, 32'h0});
        sb.push_back({32'h0, 32'hB0});
        sb.push_back({32'h4, 32'hB1});
        sb.push_back({32'h8, 32'hB2});
        src.push_back({1'b0, 32'hB0});
        src.push_back({1'b0, 32'hB1});
        src.push_back({1'b0, 32'hB2});
        src.push_back({1'b0, 32'hB3});
        pulse_start();
        n = 0;
        while (!error && n < 300) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        check("t5_err", 32'(error), 32'd1);
        check("t5_wc", 32'(word_count), 32'd3);
        check("t5_src_left", 32'(src.size()), 32'd0);
        check("t5_sb_left", 32'(sb.size()), 32'd0);
        check("t5_awv", 32'(awvalid), 32'd0);

        // reset during WR_REQ, then a fresh load
        do_reset();
        aw_delay = 5;
        sb.push_back({BOOT, 32'h0});
        sb.push_back({32'h0, 32'hD0});
        src.push_back({1'b0, 32'hD0});
        src.push_back({1'b1, 32'hD1});
        pulse_start();
        n = 0;
        while (!(awvalid && awaddr == 32'h0) && n < 100) begin
            @(negedge clk); n++;
        end
        check("t6_in_wr", 32'(awvalid), 32'd1);
        rst_n = 0;
        @(posedge clk);
        #1;
        check("t6_awv", 32'(awvalid), 32'd0);
        check("t6_wv", 32'(wvalid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_trdy", 32'(tready), 32'd0);
        @(negedge clk);
        aw_delay = 0;
        do_reset();
        sb.push_back({BOOT, 32'h0});
        sb.push_back({32'h0, 32'hE0});
        sb.push_back({BOOT, 32'h1});
        src.push_back({1'b1, 32'hE0});
        pulse_start();
        n = 0;
        while (!done && n < 300) begin @(negedge clk); n++; end
        check("t6_done", 32'(done), 32'd1);
        check("t6_wc", 32'(word_count), 32'd1);
        check("t6_sb_left", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
